// File: rtl/md5_pkg.sv
// md5_pkg: constants and shared types for the MD5 padder / block engine pair.
//   K_TAB, SHIFT_TAB : per-round additive constants and left-rotate amounts
//   IV0..IV3         : initial chaining values
//   STAT_*           : padder status encodings (also used by md5_padding)
//   state_t          : block engine FSM states
//   bswap32, rotl32, msg_idx : small helpers used by the engine and round logic
package md5_pkg;

  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hefcdab89;
  localparam logic [31:0] IV2 = 32'h98badcfe;
  localparam logic [31:0] IV3 = 32'h10325476;

  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_BUSY = 2'b01;
  localparam logic [1:0] STAT_MORE = 2'b10;
  localparam logic [1:0] STAT_LAST = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] SHIFT_TAB [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  // Message word index per round quarter; all arithmetic wraps mod 16,
  // so only the low 4 bits of the round number matter.
  function automatic logic [3:0] msg_idx(input logic [5:0] r);
    logic [3:0] lo;
    lo = r[3:0];
    case (r[5:4])
      2'd0:    msg_idx = lo;
      2'd1:    msg_idx = (lo << 2) + lo + 4'd1;
      2'd2:    msg_idx = (lo << 1) + lo + 4'd5;
      default: msg_idx = (lo << 3) - lo;
    endcase
  endfunction

endpackage

// File: rtl/md5_block_engine_if.sv
// md5_block_engine_if: padder <-> block engine link.
//   blk_data/blk_status : padded block and status from the padder
//   resume              : request for the next block
//   digest/digest_valid : final digest and its update strobe
//   busy                : engine not idle
// master = padder side (or testbench), slave = block engine.
interface md5_block_engine_if;
  logic [0:511] blk_data;
  logic [1:0]   blk_status;
  logic         resume;
  logic [0:127] digest;
  logic         digest_valid;
  logic         busy;

  modport master (
    output blk_data, blk_status,
    input  resume, digest, digest_valid, busy
  );

  modport slave (
    input  blk_data, blk_status,
    output resume, digest, digest_valid, busy
  );
endinterface

// File: rtl/md5_round.sv
// md5_round: one combinational MD5 round.
//   a, b, c, d     : working state entering the round
//   m_g            : message word selected for this round
//   rnd            : round index 0..63
//   a_o..d_o       : working state leaving the round
module md5_round
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m_g,
  input  logic [5:0]  rnd,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);
  logic [31:0] f;
  logic [31:0] sum;

  always_comb begin
    case (rnd[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    sum = a + f + K_TAB[rnd] + m_g;
    a_o = d;
    d_o = c;
    c_o = b;
    b_o = b + rotl32(sum, SHIFT_TAB[rnd]);
  end
endmodule

// File: rtl/md5_block_engine.sv
// md5_block_engine: iterative MD5 compression, chained across padded blocks.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : md5_block_engine_if.slave (block in, resume/digest/busy out)
// Optional build macro MD5_UNROLL2_EN: two chained rounds per cycle
// (32 round cycles instead of 64); digests are identical either way.
module md5_block_engine
  import md5_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  md5_block_engine_if.slave bus
);
`ifdef MD5_UNROLL2_EN
  localparam logic [5:0] RND_STEP = 6'd2;
  localparam logic [5:0] RND_LAST = 6'd62;
`else
  localparam logic [5:0] RND_STEP = 6'd1;
  localparam logic [5:0] RND_LAST = 6'd63;
`endif

  state_t      state_q, state_d;
  logic [31:0] msg_q [16];
  logic [31:0] h_q [4];
  logic [31:0] a_q, b_q, c_q, d_q;
  logic [5:0]  rnd_q;
  logic        is_last_q;
  logic [0:127] digest_q;
  logic        dv_q, resume_q;

  logic [31:0] r_a, r_b, r_c, r_d;
  logic [31:0] mg0;
  logic [31:0] sum0, sum1, sum2, sum3;

  assign mg0 = msg_q[msg_idx(rnd_q)];

`ifdef MD5_UNROLL2_EN
  logic [31:0] r0_a, r0_b, r0_c, r0_d;
  logic [31:0] mg1;
  // rnd_q is always even here, so OR-ing in bit 0 names the second round.
  assign mg1 = msg_q[msg_idx(rnd_q | 6'd1)];

  md5_round u_round0 (
    .a(a_q), .b(b_q), .c(c_q), .d(d_q), .m_g(mg0), .rnd(rnd_q),
    .a_o(r0_a), .b_o(r0_b), .c_o(r0_c), .d_o(r0_d)
  );
  md5_round u_round1 (
    .a(r0_a), .b(r0_b), .c(r0_c), .d(r0_d), .m_g(mg1), .rnd(rnd_q | 6'd1),
    .a_o(r_a), .b_o(r_b), .c_o(r_c), .d_o(r_d)
  );
`else
  md5_round u_round0 (
    .a(a_q), .b(b_q), .c(c_q), .d(d_q), .m_g(mg0), .rnd(rnd_q),
    .a_o(r_a), .b_o(r_b), .c_o(r_c), .d_o(r_d)
  );
`endif

  assign sum0 = h_q[0] + a_q;
  assign sum1 = h_q[1] + b_q;
  assign sum2 = h_q[2] + c_q;
  assign sum3 = h_q[3] + d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.blk_status[1]) state_d = ST_ROUND;
      ST_ROUND: if (rnd_q == RND_LAST) state_d = ST_ADD;
      ST_ADD:   state_d = ST_DRAIN;
      // Waiting for the status to drop keeps a held block from being re-used.
      ST_DRAIN: if (!bus.blk_status[1]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) msg_q[i] <= '0;
      h_q[0]    <= IV0;
      h_q[1]    <= IV1;
      h_q[2]    <= IV2;
      h_q[3]    <= IV3;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      rnd_q     <= '0;
      is_last_q <= 1'b0;
      digest_q  <= '0;
      dv_q      <= 1'b0;
      resume_q  <= 1'b0;
    end else begin
      dv_q     <= 1'b0;
      resume_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.blk_status[1]) begin
            // Bit 0 of the block is the MSB of byte 0; MD5 words are little-endian.
            for (int i = 0; i < 16; i++) msg_q[i] <= bswap32(bus.blk_data[32*i +: 32]);
            a_q       <= h_q[0];
            b_q       <= h_q[1];
            c_q       <= h_q[2];
            d_q       <= h_q[3];
            rnd_q     <= '0;
            is_last_q <= bus.blk_status[0];
          end
        end
        ST_ROUND: begin
          a_q   <= r_a;
          b_q   <= r_b;
          c_q   <= r_c;
          d_q   <= r_d;
          rnd_q <= rnd_q + RND_STEP;
        end
        ST_ADD: begin
          if (is_last_q) begin
            digest_q <= {bswap32(sum0), bswap32(sum1), bswap32(sum2), bswap32(sum3)};
            dv_q     <= 1'b1;
            h_q[0]   <= IV0;
            h_q[1]   <= IV1;
            h_q[2]   <= IV2;
            h_q[3]   <= IV3;
          end else begin
            h_q[0]   <= sum0;
            h_q[1]   <= sum1;
            h_q[2]   <= sum2;
            h_q[3]   <= sum3;
            resume_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resume       = resume_q;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = dv_q;
  assign bus.busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_md5_block_engine.sv
// tb_md5_block_engine: directed-vector bench for md5_block_engine.
// Drives padded blocks (built by a small padding model) and compares
// digests, pulse counts, latency and busy against hand-known constants.
// Build with MD5_UNROLL2_EN defined to exercise the two-rounds-per-cycle variant.
module tb_md5_block_engine;
  import md5_pkg::*;

`ifdef MD5_UNROLL2_EN
  localparam int EXP_LAT = 34;
`else
  localparam int EXP_LAT = 66;
`endif

  localparam logic [127:0] DIG_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] DIG_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] DIG_80    = 128'h57edf4a22be3c955ac49da2e2107b67a;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  md5_block_engine_if bus ();

  md5_block_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [0:511] pad_block(input string msg, input int blk);
    logic [0:511] b;
    logic [63:0]  bits;
    logic [7:0]   by;
    int           len, nb, idx;
    len  = msg.len();
    nb   = (len + 8) / 64 + 1;
    bits = 64'(len) * 64'd8;
    b    = '0;
    for (int j = 0; j < 64; j++) begin
      idx = blk * 64 + j;
      if (idx < len)                by = msg[idx];
      else if (idx == len)          by = 8'h80;
      else if (idx >= nb * 64 - 8)  by = bits[8*(idx - (nb*64 - 8)) +: 8];
      else                          by = 8'h00;
      b[8*j +: 8] = by;
    end
    return b;
  endfunction

  // Present one block, wait (bounded) for resume/digest_valid, optionally
  // keep the status held, then drop it and let the engine return to idle.
  task automatic run_block(input string tag, input logic [0:511] blk, input logic [1:0] st,
                           input logic [1:0] drop_st, input int hold,
                           input int exp_res, input int exp_dv, input logic [127:0] exp_dig);
    int           n, lat, nres, ndv, both;
    logic [127:0] dig;
    logic         busy_hold;
    lat = 0; nres = 0; ndv = 0; both = 0; dig = '0; busy_hold = 1'b1; n = 0;
    bus.blk_data   = blk;
    bus.blk_status = st;
    while (lat == 0 && n < EXP_LAT + 40) begin
      @(negedge clk);
      n++;
      if (bus.resume) nres++;
      if (bus.digest_valid) begin ndv++; dig = bus.digest; end
      if (bus.resume && bus.digest_valid) both++;
      if (bus.resume || bus.digest_valid) lat = n;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.resume) nres++;
      if (bus.digest_valid) ndv++;
      if (bus.resume && bus.digest_valid) both++;
      if (!bus.busy) busy_hold = 1'b0;
    end
    bus.blk_status = drop_st;
    @(negedge clk);
    check({tag, "/latency"}, 128'(lat), 128'(EXP_LAT));
    check({tag, "/resume_cnt"}, 128'(nres), 128'(exp_res));
    check({tag, "/dv_cnt"}, 128'(ndv), 128'(exp_dv));
    check({tag, "/overlap"}, 128'(both), 128'(0));
    check({tag, "/busy_after"}, 128'(bus.busy), 128'(0));
    if (exp_dv != 0) check({tag, "/digest"}, dig, exp_dig);
    if (hold > 0) check({tag, "/busy_hold"}, 128'(busy_hold), 128'(1));
  endtask

  initial begin
    string s80;
    total = 0;
    bad   = 0;
    s80   = "";
    for (int i = 0; i < 8; i++) s80 = {s80, "1234567890"};

    bus.blk_data   = '0;
    bus.blk_status = STAT_IDLE;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/digest", bus.digest, 128'h0);
    check("reset/dv", 128'(bus.digest_valid), 128'(0));
    check("reset/resume", 128'(bus.resume), 128'(0));
    check("reset/busy", 128'(bus.busy), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    run_block("abc", pad_block("abc", 0), STAT_LAST, STAT_IDLE, 0, 0, 1, DIG_ABC);
    run_block("empty", pad_block("", 0), STAT_LAST, STAT_IDLE, 0, 0, 1, DIG_EMPTY);

    run_block("m80_b1", pad_block(s80, 0), STAT_MORE, STAT_BUSY, 0, 1, 0, '0);
    bus.blk_status = STAT_IDLE;
    @(negedge clk);
    run_block("m80_b2", pad_block(s80, 1), STAT_LAST, STAT_IDLE, 0, 0, 1, DIG_80);

    run_block("hold", pad_block("abc", 0), STAT_LAST, STAT_IDLE, 300, 0, 1, DIG_ABC);
    check("hold/digest_kept", bus.digest, DIG_ABC);

    // Abandon a message part-way through the rounds.
    bus.blk_data   = pad_block("abc", 0);
    bus.blk_status = STAT_LAST;
    repeat (31) @(negedge clk);
    check("rst_mid/busy_before", 128'(bus.busy), 128'(1));
    rst = 1'b0;
    bus.blk_status = STAT_IDLE;
    #1;
    check("rst_mid/digest", bus.digest, 128'h0);
    check("rst_mid/dv", 128'(bus.digest_valid), 128'(0));
    check("rst_mid/resume", 128'(bus.resume), 128'(0));
    check("rst_mid/busy", 128'(bus.busy), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_block("replay", pad_block("abc", 0), STAT_LAST, STAT_IDLE, 0, 0, 1, DIG_ABC);

    // Back-to-back messages: the second must start from the IV again.
    run_block("b2b_abc", pad_block("abc", 0), STAT_LAST, STAT_IDLE, 0, 0, 1, DIG_ABC);
    run_block("b2b_empty", pad_block("", 0), STAT_LAST, STAT_IDLE, 0, 0, 1, DIG_EMPTY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
